// File: rtl/pc_sequencer.sv
// Fetch-side program counter sequencer: run/step/halt control, instruction limit,
// per-cycle commit strobe and next-PC fault detection (misalignment and wrap).
module pc_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MAX_INSTR = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic             halt_req,
  input  logic [31:0]      Output_Addr,
  output logic [31:0]      Input_Addr,
  output logic             commit,
  output logic             running,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] instr_count
);

  if (MAX_INSTR == 0 || 64'(MAX_INSTR) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_limit
    $error("pc_sequencer: MAX_INSTR must be in 1..2**CNT_W-1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state, state_nx;
  logic [31:0]       pc_nx;
  logic [CNT_W-1:0]  cnt_nx;
  logic [1:0]        code_nx;
  logic              misaligned, wrap, fault, active;
  logic [CNT_W:0]    cnt_inc;
  logic              limit_hit;

  assign misaligned = (Output_Addr[1:0] != 2'b00);
  assign wrap       = (Output_Addr < Input_Addr);
  assign fault      = misaligned | wrap;
  // A cycle wants to advance in RUN always, in STEP only while step is high.
  assign active     = (state == S_RUN) | ((state == S_STEP) & step);
  assign commit     = active & ~halt_req & ~fault;

  assign cnt_inc    = {1'b0, instr_count} + (CNT_W+1)'(1);
  assign limit_hit  = (cnt_inc == (CNT_W+1)'(MAX_INSTR));

  assign running    = (state == S_RUN) | (state == S_STEP);
  assign done       = (state == S_DONE);
  assign err        = (state == S_ERR);

  always_comb begin
    state_nx = state;
    pc_nx    = Input_Addr;
    cnt_nx   = instr_count;
    code_nx  = err_code;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          pc_nx    = RESET_PC;
          cnt_nx   = '0;
          code_nx  = 2'b00;
          state_nx = step_mode ? S_STEP : S_RUN;
        end
      end
      S_RUN, S_STEP: begin
        if (halt_req) begin
          state_nx = S_IDLE;
        end else if (active && fault) begin
          state_nx = S_ERR;
          code_nx  = misaligned ? 2'b01 : 2'b10;
        end else if (commit) begin
          pc_nx  = Output_Addr;
          cnt_nx = cnt_inc[CNT_W] ? instr_count : cnt_inc[CNT_W-1:0];
          if (limit_hit) state_nx = S_DONE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      Input_Addr  <= RESET_PC;
      instr_count <= '0;
      err_code    <= 2'b00;
    end else begin
      state       <= state_nx;
      Input_Addr  <= pc_nx;
      instr_count <= cnt_nx;
      err_code    <= code_nx;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: scoreboard of expected commit PCs plus state checks;
// a second instance with a high RESET_PC exercises address wrap.
module tb_pc_sequencer;

  logic        clk;
  logic        rst, start, start1, step_mode, step, halt_req;
  logic        force_en;
  logic [31:0] force_val;

  logic [31:0] out0, in0, out1, in1;
  logic        commit0, running0, done0, err0;
  logic        commit1, running1, done1, err1;
  logic [1:0]  err_code0, err_code1;
  logic [15:0] count0, count1;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] exp_q[$];

  assign out0 = force_en ? force_val : in0 + 32'd4;
  assign out1 = in1 + 32'd4;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .MAX_INSTR(16), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step),
    .halt_req(halt_req), .Output_Addr(out0), .Input_Addr(in0), .commit(commit0),
    .running(running0), .done(done0), .err(err0), .err_code(err_code0),
    .instr_count(count0)
  );

  pc_sequencer #(.RESET_PC(32'hFFFF_FFF8), .MAX_INSTR(16), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .step_mode(step_mode), .step(step),
    .halt_req(halt_req), .Output_Addr(out1), .Input_Addr(in1), .commit(commit1),
    .running(running1), .done(done1), .err(err1), .err_code(err_code1),
    .instr_count(count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: scoreboard the dut0 commit of this cycle, then cross the edge.
  task automatic tick();
    logic [31:0] e;
    #1;
    if (commit0 === 1'b1) begin
      if (exp_q.size() == 0) chk("commit_without_expect", 32'(commit0), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("commit_pc", in0, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse(input logic mode);
    start = 1'b1;
    step_mode = mode;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start1 = 1'b0; step_mode = 1'b0; step = 1'b0;
    halt_req = 1'b0; force_en = 1'b0; force_val = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // T1: reset values, free run to the instruction limit
    chk("rst_pc", in0, 32'h0);
    chk("rst_count", 32'(count0), 32'd0);
    chk("rst_flags", {28'h0, running0, done0, err0, commit0}, 32'h0);
    chk("rst_err_code", 32'(err_code0), 32'd0);
    chk("rst_pc1", in1, 32'hFFFF_FFF8);
    start_pulse(1'b0);
    chk("t1_running", 32'(running0), 32'd1);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(i * 4));
    for (int i = 0; i < 16; i++) tick();
    chk("t1_drained", 32'(exp_q.size()), 32'd0);
    chk("t1_done", 32'(done0), 32'd1);
    chk("t1_count", 32'(count0), 32'd16);
    chk("t1_pc", in0, 32'd64);
    #1 chk("t1_no_commit_done", 32'(commit0), 32'd0);
    tick();

    // T2: single-step with idle gaps
    start_pulse(1'b1);
    chk("t2_pc_reload", in0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      exp_q.push_back(32'(i * 4));
      tick();
      step = 1'b0;
      #1 chk("t2_idle_no_commit", 32'(commit0), 32'd0);
      tick();
    end
    chk("t2_drained", 32'(exp_q.size()), 32'd0);
    chk("t2_pc", in0, 32'd12);
    chk("t2_count", 32'(count0), 32'd3);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("t2_halt_idle", 32'(running0), 32'd0);
    chk("t2_halt_pc", in0, 32'd12);

    // T3: halt in RUN at count 5, then restart
    start_pulse(1'b0);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    for (int i = 0; i < 5; i++) tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("t3_drained", 32'(exp_q.size()), 32'd0);
    chk("t3_running", 32'(running0), 32'd0);
    chk("t3_done", 32'(done0), 32'd0);
    chk("t3_pc", in0, 32'd20);
    chk("t3_count", 32'(count0), 32'd5);
    tick();
    chk("t3_idle_hold_pc", in0, 32'd20);
    start_pulse(1'b0);
    chk("t3_restart_pc", in0, 32'h0);
    chk("t3_restart_count", 32'(count0), 32'd0);

    // T4: misaligned next-PC at PC=4
    exp_q.push_back(32'h0);
    tick();
    force_val = 32'h0000_0006;
    force_en = 1'b1;
    #1 chk("t4_no_commit", 32'(commit0), 32'd0);
    tick();
    force_en = 1'b0;
    chk("t4_err", 32'(err0), 32'd1);
    chk("t4_err_code", 32'(err_code0), 32'd1);
    chk("t4_pc", in0, 32'd4);
    chk("t4_count", 32'(count0), 32'd1);

    // Misaligned and wrap together: misaligned wins
    start_pulse(1'b0);
    chk("t4b_err_cleared", 32'(err_code0), 32'd0);
    exp_q.push_back(32'h0);
    tick();
    force_val = 32'h0000_0002;
    force_en = 1'b1;
    tick();
    force_en = 1'b0;
    chk("t4b_err_code", 32'(err_code0), 32'd1);
    chk("t4b_pc", in0, 32'd4);

    // T5: wrap past the top of the address space
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("t5_start_pc", in1, 32'hFFFF_FFF8);
    #1 chk("t5_commit", 32'(commit1), 32'd1);
    tick();
    chk("t5_pc_top", in1, 32'hFFFF_FFFC);
    chk("t5_count", 32'(count1), 32'd1);
    #1 chk("t5_wrap_no_commit", 32'(commit1), 32'd0);
    tick();
    chk("t5_err", 32'(err1), 32'd1);
    chk("t5_err_code", 32'(err_code1), 32'd2);
    chk("t5_pc_hold", in1, 32'hFFFF_FFFC);

    // T6: asynchronous reset between edges during RUN
    start_pulse(1'b0);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd4);
    tick();
    tick();
    chk("t6_pc_before", in0, 32'd8);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_pc", in0, 32'h0);
    chk("t6_async_count", 32'(count0), 32'd0);
    chk("t6_async_flags", {29'h0, running0, commit0, err1}, 32'h0);
    chk("t6_async_pc1", in1, 32'hFFFF_FFF8);
    chk("t6_async_err_code1", 32'(err_code1), 32'd0);
    #1 rst = 1'b0;
    tick();
    chk("t6_stays_idle", 32'(running0), 32'd0);
    chk("t6_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
